// File: rtl/convolution_module_1.sv
// Layer-1 streaming 2D convolution: KSIZE x KSIZE kernel plus bias over a raster IMG_W x IMG_H Q8.8 image.
// Define CONV1_RELU_EN to fuse a ReLU after saturation; the default build passes signed results through.
module convolution_module_1 #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int KSIZE = 5,
   parameter int FRAC  = 8,
   parameter int ACC_W = 40
) (
   input  logic        Clock,
   input  logic        Input_Reset,
   input  logic [15:0] Input_Pixel,
   input  logic        Input_Valid,
   input  logic        Input_Finish,
   input  logic        Weight_Write,
   input  logic [4:0]  Weight_Addr,
   input  logic [15:0] Weight_Data,
   output logic [15:0] Output_Pixel,
   output logic        Output_Valid,
   output logic        Output_Finish,
   output logic [15:0] Watch
);

   localparam int NTAP = KSIZE * KSIZE;
   localparam int WAW  = $clog2(NTAP);
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   // line_buf[0] holds the previous row, line_buf[k] the row k+1 above the current one
   logic signed [15:0] line_buf [KSIZE-1][IMG_W];
   logic signed [15:0] win      [KSIZE][KSIZE];
   logic signed [15:0] weight   [NTAP];
   logic signed [15:0] bias;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          last_pixel;

   logic                    win_valid, win_finish;
   logic                    acc_valid, acc_finish;
   logic signed [ACC_W-1:0] acc, acc_next;
   logic signed [ACC_W-1:0] shifted;
   logic signed [15:0]      result;

   assign last_pixel = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
   assign Watch      = {8'(row), 8'(col)};

   // NOTE: always_comb outputs get a default on entry so no path can infer a latch.
   always_comb begin
      logic signed [31:0] prod;
      prod     = '0;
      acc_next = ACC_W'(bias) <<< FRAC;
      for (int i = 0; i < KSIZE; i++) begin
         for (int j = 0; j < KSIZE; j++) begin
            prod     = win[i][j] * weight[i*KSIZE + j];
            acc_next = acc_next + ACC_W'(prod);
         end
      end
   end

   always_comb begin
      shifted = acc >>> FRAC;
      if (shifted > SAT_MAX)      result = 16'sh7FFF;
      else if (shifted < SAT_MIN) result = 16'sh8000;
      else                        result = shifted[15:0];
`ifdef CONV1_RELU_EN
      if (result[15]) result = '0;
`endif
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Input_Reset) begin
         // NOTE: line buffers and window are cleared on reset as well, so a fresh frame never sees stale data.
         for (int k = 0; k < KSIZE-1; k++)
            for (int c = 0; c < IMG_W; c++)
               line_buf[k][c] <= '0;
         for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
               win[i][j] <= '0;
         for (int t = 0; t < NTAP; t++)
            weight[t] <= '0;
         bias          <= '0;
         row           <= '0;
         col           <= '0;
         win_valid     <= 1'b0;
         win_finish    <= 1'b0;
         acc           <= '0;
         acc_valid     <= 1'b0;
         acc_finish    <= 1'b0;
         Output_Pixel  <= '0;
         Output_Valid  <= 1'b0;
         Output_Finish <= 1'b0;
      end else begin
         if (Weight_Write) begin
            if (Weight_Addr < 5'(NTAP))       weight[Weight_Addr[WAW-1:0]] <= Weight_Data;
            else if (Weight_Addr == 5'(NTAP)) bias <= Weight_Data;
         end

         if (Input_Valid) begin
            // Window shifts left; the new right column is this pixel's column, oldest row on top
            for (int i = 0; i < KSIZE; i++)
               for (int j = 0; j < KSIZE-1; j++)
                  win[i][j] <= win[i][j+1];
            for (int i = 0; i < KSIZE-1; i++)
               win[i][KSIZE-1] <= line_buf[KSIZE-2-i][col];
            win[KSIZE-1][KSIZE-1] <= Input_Pixel;

            line_buf[0][col] <= Input_Pixel;
            for (int k = 1; k < KSIZE-1; k++)
               line_buf[k][col] <= line_buf[k-1][col];

            if (col == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         if (Input_Finish) begin
            row <= '0;
            col <= '0;
         end

         win_valid  <= Input_Valid && (row >= RW'(KSIZE - 1)) && (col >= CW'(KSIZE - 1));
         win_finish <= (Input_Valid && last_pixel) || Input_Finish;

         acc        <= acc_next;
         acc_valid  <= win_valid;
         acc_finish <= win_finish;

         Output_Valid  <= acc_valid;
         Output_Finish <= acc_finish;
         if (acc_valid) Output_Pixel <= result;
      end
   end

endmodule

// File: tb/tb_convolution_module_1.sv
// Scoreboard bench for convolution_module_1: a 2D-image reference model predicts every output and its cycle.
// Honours CONV1_RELU_EN in the model so the same bench covers both builds.
module tb_convolution_module_1;

   localparam int W = 28;
   localparam int H = 28;
   localparam int K = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_pix;
   logic        in_valid, in_fin, w_wr;
   logic [4:0]  w_addr;
   logic [15:0] w_data;
   logic [15:0] out_pix;
   logic        out_valid, out_fin;
   logic [15:0] watch;

   always #5 clk = ~clk;

   convolution_module_1 dut (
      .Clock         (clk),
      .Input_Reset   (rst),
      .Input_Pixel   (in_pix),
      .Input_Valid   (in_valid),
      .Input_Finish  (in_fin),
      .Weight_Write  (w_wr),
      .Weight_Addr   (w_addr),
      .Weight_Data   (w_data),
      .Output_Pixel  (out_pix),
      .Output_Valid  (out_valid),
      .Output_Finish (out_fin),
      .Watch         (watch)
   );

   typedef struct {
      logic        valid;
      logic        finish;
      logic [15:0] pix;
      int          cycle;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   n_out    = 0;

   // reference model state
   int m_w [K*K];
   int m_bias;
   int img [H][W];
   int m_row, m_col;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [15:0] model_out(int r, int c);
      longint s;
      s = longint'(m_bias) * 256;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            s += longint'(m_w[i*K + j]) * longint'(img[r+i][c+j]);
      s = s >>> 8;
      if (s > 32767)       s = 32767;
      else if (s < -32768) s = -32768;
`ifdef CONV1_RELU_EN
      if (s < 0) s = 0;
`endif
      return 16'(s);
   endfunction

   task automatic model_accept(logic [15:0] p, logic v, logic f, int when);
      exp_t e;
      e.valid = 1'b0; e.finish = 1'b0; e.pix = '0; e.cycle = when;
      if (v) begin
         img[m_row][m_col] = int'($signed(p));
         if (m_row >= K-1 && m_col >= K-1) begin
            e.valid = 1'b1;
            e.pix   = model_out(m_row-K+1, m_col-K+1);
         end
         if (m_row == H-1 && m_col == W-1) e.finish = 1'b1;
         m_col++;
         if (m_col == W) begin
            m_col = 0;
            m_row++;
            if (m_row == H) m_row = 0;
         end
      end
      if (f) begin
         e.finish = 1'b1;
         m_row = 0;
         m_col = 0;
      end
      if (e.valid || e.finish) sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The pixel set now is sampled at the next edge; its output is visible two edges after that.
   task automatic drive(logic [15:0] p, logic v, logic f);
      in_pix = p; in_valid = v; in_fin = f;
      if (v || f) model_accept(p, v, f, cyc + 3);
      tick();
      in_valid = 1'b0; in_fin = 1'b0; in_pix = 16'($urandom);
   endtask

   // kind 0: ramp r*W+c, 1: constant cval, 2: random small signed
   task automatic send_pixels(int n, int kind, logic [15:0] cval, int gap_pct, bit fin_last);
      logic [15:0] p;
      for (int k = 0; k < n; k++) begin
         while (int'($urandom_range(99)) < gap_pct) drive(16'($urandom), 1'b0, 1'b0);
         case (kind)
            0:       p = 16'(m_row * W + m_col);
            1:       p = cval;
            default: p = 16'(int'($urandom_range(2047)) - 1024);
         endcase
         drive(p, 1'b1, fin_last && (k == n-1));
      end
   endtask

   task automatic write_weight(logic [4:0] a, logic [15:0] d);
      w_wr = 1'b1; w_addr = a; w_data = d;
      if (a < 5'(K*K))       m_w[a] = int'($signed(d));
      else if (a == 5'(K*K)) m_bias = int'($signed(d));
      tick();
      w_wr = 1'b0;
   endtask

   task automatic set_all_weights(logic [15:0] d, logic [15:0] b);
      for (int t = 0; t < K*K; t++) write_weight(5'(t), d);
      write_weight(5'(K*K), b);
   endtask

   task automatic drain();
      repeat (4) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      while (sb.size() > 0 && sb[sb.size()-1].cycle >= cyc + 1) void'(sb.pop_back());
      tick();
      check("reset_pixel",  32'(out_pix),   32'h0);
      check("reset_valid",  32'(out_valid), 32'h0);
      check("reset_finish", 32'(out_fin),   32'h0);
      check("reset_watch",  32'(watch),     32'h0);
      tick();
      rst = 1'b0;
      for (int t = 0; t < K*K; t++) m_w[t] = 0;
      m_bias = 0;
      m_row  = 0;
      m_col  = 0;
   endtask

   // monitor
   always @(negedge clk) begin
      if (out_valid === 1'b1 || out_fin === 1'b1) begin
         if (sb.size() == 0) begin
            check("stray_output", 32'({out_valid, out_fin}), 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_out++;
            check("out_valid",  32'(out_valid), 32'(e.valid));
            check("out_finish", 32'(out_fin),   32'(e.finish));
            if (e.valid) check("out_pixel", 32'(out_pix), 32'(e.pix));
            check("latency", 32'(cyc), 32'(e.cycle));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_pix = '0; in_valid = 1'b0; in_fin = 1'b0;
      w_wr = 1'b0; w_addr = '0; w_data = '0;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 0;
      tick();
      do_reset();

      // identity kernel, ramp frame, then the same frame with 50% gaps back to back
      write_weight(5'd12, 16'h0100);
      send_pixels(100, 0, 16'h0, 0, 1'b0);
      check("watch_mid", 32'(watch), 32'({8'(m_row), 8'(m_col)}));
      send_pixels(H*W - 100, 0, 16'h0, 0, 1'b0);
      send_pixels(H*W, 0, 16'h0, 50, 1'b0);
      drain();

      // box filter
      set_all_weights(16'h0100, 16'h0000);
      send_pixels(H*W, 1, 16'h0100, 0, 1'b0);
      drain();

      // saturation both directions
      set_all_weights(16'h7FFF, 16'h0000);
      send_pixels(H*W, 1, 16'h7FFF, 0, 1'b0);
      send_pixels(H*W, 1, 16'h8000, 10, 1'b0);
      drain();

      // negative bias only; out-of-range address must be ignored
      set_all_weights(16'h0000, 16'hFF00);
      write_weight(5'd30, 16'h4000);
      send_pixels(H*W, 2, 16'h0, 0, 1'b0);
      drain();

      // random kernel and bias, random data with gaps
      for (int t = 0; t < K*K; t++) write_weight(5'(t), 16'(int'($urandom_range(1023)) - 512));
      write_weight(5'(K*K), 16'(int'($urandom_range(4095)) - 2048));
      send_pixels(H*W, 2, 16'h0, 30, 1'b0);
      drain();

      // early finish on a window-completing pixel, a bare finish, then a full frame
      set_all_weights(16'h0000, 16'h0000);
      write_weight(5'd12, 16'h0100);
      send_pixels(150, 0, 16'h0, 0, 1'b1);
      check("watch_after_finish", 32'(watch), 32'h0);
      drain();
      drive(16'h0, 1'b0, 1'b1);
      drain();
      send_pixels(H*W, 0, 16'h0, 20, 1'b0);
      drain();

      // reset mid-frame right after pixel 300, reload, full frame
      send_pixels(300, 0, 16'h0, 0, 1'b0);
      do_reset();
      drain();
      write_weight(5'd12, 16'h0100);
      send_pixels(H*W, 0, 16'h0, 0, 1'b0);
      drain();

      check("scoreboard_empty", 32'(sb.size()), 32'h0);
      check("outputs_seen_nonzero", 32'(n_out > 5000), 32'h1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
